wb_cmd_master: RTL

- Upstream Wishbone-style master feeding the team's 8-bit-address / 8-bit-data memory slave. The slave uses wr/strb/addr/wdata/rdata/ack.
- Accepts read/write commands from a host over a valid/ready channel and buffers them in a small FIFO.
- Issues the commands to the slave one at a time, waits for ack, and returns one response per command.
- Guards each transaction with a timeout so a non-responding slave cannot hang the host.

---
 rtl/wb_cmd_master.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// Command-queue master for the 8-bit Wishbone-style memory slave: buffers host
// commands in a FIFO, issues them one at a time, and returns one response each.
module wb_cmd_master #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_wr,
    input  logic [7:0]                 cmd_addr,
    input  logic [7:0]                 cmd_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_wr,
    output logic [7:0]                 rsp_rdata,
    output logic                       rsp_err,
    output logic                       wr,
    output logic                       strb,
    output logic [7:0]                 addr,
    output logic [7:0]                 wdata,
    input  logic [7:0]                 rdata,
    input  logic                       ack,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          strb_q, strb_d;
    logic          wr_q, wr_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_wr_q, rsp_wr_d;
    logic          rsp_err_q, rsp_err_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [16:0]   mem_q [DEPTH];

    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          launch_s;
    logic [16:0]   head_s;

    // FIFO status, handshake and launch decision
    always_comb begin
        full_s   = (level_q == LW'(DEPTH));
        empty_s  = (level_q == LW'(0));
        push_s   = cmd_valid && !full_s;
        // The response slot frees up in the same cycle the host accepts it.
        launch_s = (state_q == S_IDLE) && !empty_s && (!rsp_valid_q || rsp_ready);
        head_s   = mem_q[rptr_q];
    end

    // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push_s) begin
            wptr_d = wptr_q + AW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (launch_s) begin
            rptr_d = rptr_q + AW'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, launch_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Transaction FSM: next state, bus outputs and response loading
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        strb_d      = strb_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (launch_s) begin
                    strb_d  = 1'b1;
                    wr_d    = head_s[16];
                    addr_d  = head_s[15:8];
                    wdata_d = head_s[7:0];
                    cnt_d   = 8'd0;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                // ack on the expiry cycle still counts as success
                if (ack) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_wr_d    = wr_q;
                    rsp_rdata_d = wr_q ? 8'h00 : rdata;
                    strb_d      = 1'b0;
                    state_d     = S_GAP;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_wr_d    = wr_q;
                    rsp_rdata_d = 8'h00;
                    strb_d      = 1'b0;
                    state_d     = S_GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                strb_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Control and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            strb_q      <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 8'h00;
            busy_q      <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            strb_q      <= strb_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= {cmd_wr, cmd_addr, cmd_wdata};
        end
    end

    assign cmd_ready  = !full_s;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_wr     = rsp_wr_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign wr         = wr_q;
    assign strb       = strb_q;
    assign addr       = addr_q;
    assign wdata      = wdata_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;

endmodule
